// File: rtl/dmac_pkg.sv
// dmac_pkg: shared DMA controller widths, channel count default and AR/AW slot state.
package dmac_pkg;
  localparam int DMAC_N_CH   = 4;
  localparam int DMAC_ADDR_W = 32;
  localparam int LEN_W       = 4;
  localparam int SIZE_W      = 3;
  localparam int BURST_W     = 2;
  localparam int ID_W        = 4;
  typedef enum logic {ST_EMPTY, ST_FULL} dmac_state_e;
endpackage

// File: rtl/dmac_rr_pick.sv
// dmac_rr_pick: combinational round-robin picker.
// Ports: req (request vector), last (previous winner index),
//        gnt (one-hot winner, nearest request after last with wrap), valid (any request).
module dmac_rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [N-1:0]  gnt,
  output logic          valid
);
  int best;
  // Distance of channel j from the slot after last; the smallest requested distance wins.
  always_comb begin
    gnt = '0;
    best = N;
    for (int j = 0; j < N; j++)
      if (req[j] && (j - int'(last) - 1 + N) % N < best) begin
        best = (j - int'(last) - 1 + N) % N;
        gnt = N'(1) << j;
      end
  end
  assign valid = |req;
endmodule

// File: rtl/dmac_ar_arbiter.sv
// dmac_ar_arbiter: round-robin arbiter of N_CH channel address requests onto one registered AXI address channel.
// Ports: clk, rst (async, active-high); src_arvalid_i/src_araddr_i/src_arlen_i/src_arsize_i/src_arburst_i
//        (packed per-channel requests); src_arready_o (one-hot accept); arid_o/araddr_o/arlen_o/arsize_o/
//        arburst_o/arvalid_o with arready_i (registered output channel); grant_o (one-hot slot owner).
module dmac_ar_arbiter
  import dmac_pkg::*;
#(
  parameter int N_CH   = DMAC_N_CH,
  parameter int ADDR_W = DMAC_ADDR_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_CH-1:0]         src_arvalid_i,
  input  logic [N_CH*ADDR_W-1:0]  src_araddr_i,
  input  logic [N_CH*LEN_W-1:0]   src_arlen_i,
  input  logic [N_CH*SIZE_W-1:0]  src_arsize_i,
  input  logic [N_CH*BURST_W-1:0] src_arburst_i,
  output logic [N_CH-1:0]         src_arready_o,
  output logic [ID_W-1:0]         arid_o,
  output logic [ADDR_W-1:0]       araddr_o,
  output logic [LEN_W-1:0]        arlen_o,
  output logic [SIZE_W-1:0]       arsize_o,
  output logic [BURST_W-1:0]      arburst_o,
  output logic                    arvalid_o,
  input  logic                    arready_i,
  output logic [N_CH-1:0]         grant_o
);
  localparam int IW = N_CH > 1 ? $clog2(N_CH) : 1;
  dmac_state_e          state;
  logic [IW-1:0]        last_q, win;
  logic [N_CH-1:0]      gnt;
  logic                 any_req, accept;
  logic [ADDR_W-1:0]    sel_addr;
  logic [LEN_W-1:0]     sel_len;
  logic [SIZE_W-1:0]    sel_size;
  logic [BURST_W-1:0]   sel_burst;
  dmac_rr_pick #(.N(N_CH), .IW(IW)) u_pick (
    .req   (src_arvalid_i),
    .last  (last_q),
    .gnt   (gnt),
    .valid (any_req)
  );
  // The slot can load when free or when its current contents leave this cycle; reset blocks accepts.
  assign accept        = !rst && any_req && (state == ST_EMPTY || arready_i);
  assign src_arready_o = accept ? gnt : '0;
  assign arvalid_o     = state == ST_FULL;
  always_comb begin
    win = '0;
    sel_addr = '0;
    sel_len = '0;
    sel_size = '0;
    sel_burst = '0;
    for (int i = 0; i < N_CH; i++)
      if (gnt[i]) begin
        win = IW'(i);
        sel_addr = src_araddr_i[i*ADDR_W +: ADDR_W];
        sel_len = src_arlen_i[i*LEN_W +: LEN_W];
        sel_size = src_arsize_i[i*SIZE_W +: SIZE_W];
        sel_burst = src_arburst_i[i*BURST_W +: BURST_W];
      end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= ST_EMPTY;
      last_q <= IW'(N_CH - 1);
      grant_o <= '0;
      arid_o <= '0;
      araddr_o <= '0;
      arlen_o <= '0;
      arsize_o <= '0;
      arburst_o <= '0;
    end else if (accept) begin
      state <= ST_FULL;
      last_q <= win;
      grant_o <= gnt;
      arid_o <= ID_W'(win);
      araddr_o <= sel_addr;
      arlen_o <= sel_len;
      arsize_o <= sel_size;
      arburst_o <= sel_burst;
    end else if (state == ST_FULL && arready_i) begin
      state <= ST_EMPTY;
      grant_o <= '0;
    end
endmodule

// File: tb/tb_dmac_ar_arbiter.sv
// tb_dmac_ar_arbiter: directed self-checking bench for dmac_ar_arbiter.
module tb_dmac_ar_arbiter;
  logic        clk = 0;
  logic        rst = 1;
  logic [3:0]  src_arvalid_i = '0;
  logic [127:0] src_araddr_i = '0;
  logic [15:0] src_arlen_i = '0;
  logic [11:0] src_arsize_i = '0;
  logic [7:0]  src_arburst_i = '0;
  logic [3:0]  src_arready_o;
  logic [3:0]  arid_o;
  logic [31:0] araddr_o;
  logic [3:0]  arlen_o;
  logic [2:0]  arsize_o;
  logic [1:0]  arburst_o;
  logic        arvalid_o;
  logic        arready_i = 0;
  logic [3:0]  grant_o;
  int tests = 0;
  int fails = 0;

  dmac_ar_arbiter dut (
    .clk(clk), .rst(rst),
    .src_arvalid_i(src_arvalid_i), .src_araddr_i(src_araddr_i), .src_arlen_i(src_arlen_i),
    .src_arsize_i(src_arsize_i), .src_arburst_i(src_arburst_i), .src_arready_o(src_arready_o),
    .arid_o(arid_o), .araddr_o(araddr_o), .arlen_o(arlen_o), .arsize_o(arsize_o),
    .arburst_o(arburst_o), .arvalid_o(arvalid_o), .arready_i(arready_i), .grant_o(grant_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int k, input logic [31:0] a, input logic [3:0] l,
                        input logic [2:0] s, input logic [1:0] b);
    src_araddr_i[k*32 +: 32] = a;
    src_arlen_i[k*4 +: 4] = l;
    src_arsize_i[k*3 +: 3] = s;
    src_arburst_i[k*2 +: 2] = b;
  endtask

  initial begin
    for (int k = 0; k < 4; k++) set_ch(k, 32'h1000 * (k + 1), 4'(k + 5), 3'(k), 2'(k % 3));
    src_arvalid_i = 4'b1111;
    tick;
    tick;
    chk("rst_arvalid", arvalid_o, 0);
    chk("rst_grant", grant_o, 0);
    chk("rst_arid", arid_o, 0);
    chk("rst_araddr", araddr_o, 0);
    chk("rst_fields", {arlen_o, arsize_o, arburst_o}, 0);
    chk("rst_srcready", src_arready_o, 0);
    // All channels requesting, sink always ready: 0,1,2,3,0 back to back.
    rst = 0;
    arready_i = 1;
    #1;
    chk("first_accept_ch0", src_arready_o, 4'b0001);
    for (int i = 0; i < 5; i++) begin
      tick;
      chk("rr_arid", arid_o, i % 4);
      chk("rr_araddr", araddr_o, 32'h1000 * (i % 4 + 1));
      chk("rr_fields", {arlen_o, arsize_o, arburst_o}, {4'((i % 4) + 5), 3'(i % 4), 2'((i % 4) % 3)});
      chk("rr_arvalid", arvalid_o, 1);
      chk("rr_grant", grant_o, 4'b0001 << (i % 4));
    end
    // Drain with no new requests, then arready_i while empty is ignored.
    src_arvalid_i = 0;
    tick;
    chk("drain_arvalid", arvalid_o, 0);
    chk("drain_grant", grant_o, 0);
    tick;
    chk("empty_ready_ignored", arvalid_o, 0);
    // Single ch2 request held by a stalled sink.
    arready_i = 0;
    set_ch(2, 32'h100, 4'd3, 3'd2, 2'd1);
    src_arvalid_i = 4'b0100;
    #1;
    chk("ch2_srcready", src_arready_o, 4'b0100);
    tick;
    chk("ch2_arid", arid_o, 2);
    chk("ch2_arlen", arlen_o, 3);
    src_arvalid_i = 4'b0010;
    #1;
    chk("stall_no_accept", src_arready_o, 0);
    for (int i = 0; i < 5; i++) begin
      chk("stall_arvalid", arvalid_o, 1);
      chk("stall_araddr", araddr_o, 32'h100);
      chk("stall_grant", grant_o, 4'b0100);
      tick;
    end
    src_arvalid_i = 0;
    arready_i = 1;
    tick;
    chk("stall_release_empty", arvalid_o, 0);
    chk("stall_release_grant", grant_o, 0);
    // Withdrawn ch1 request left last_q at 2: ch2+ch3 requests pick ch3.
    src_arvalid_i = 4'b1100;
    #1;
    chk("withdraw_last_kept", src_arready_o, 4'b1000);
    tick;
    chk("withdraw_arid", arid_o, 3);
    src_arvalid_i = 4'b0010;
    #1;
    chk("b2b_srcready", src_arready_o, 4'b0010);
    tick;
    chk("b2b_arid", arid_o, 1);
    src_arvalid_i = 0;
    tick;
    chk("idle_arvalid", arvalid_o, 0);
    // last_q=1 with ch0 and ch3 requesting: ch3 then ch0.
    src_arvalid_i = 4'b1001;
    #1;
    chk("wrap_first_ready", src_arready_o, 4'b1000);
    tick;
    chk("wrap_first_arid", arid_o, 3);
    chk("wrap_second_ready", src_arready_o, 4'b0001);
    tick;
    chk("wrap_second_arid", arid_o, 0);
    chk("wrap_second_addr", araddr_o, 32'h1000);
    src_arvalid_i = 0;
    tick;
    chk("wrap_idle", arvalid_o, 0);
    // Reset while FULL drops arvalid_o at once and restores ch0 priority.
    arready_i = 0;
    src_arvalid_i = 4'b0010;
    tick;
    chk("pre_rst_arid", arid_o, 1);
    chk("pre_rst_arvalid", arvalid_o, 1);
    rst = 1;
    #1;
    chk("async_rst_arvalid", arvalid_o, 0);
    chk("async_rst_grant", grant_o, 0);
    chk("async_rst_araddr", araddr_o, 0);
    tick;
    chk("held_rst_arvalid", arvalid_o, 0);
    chk("held_rst_srcready", src_arready_o, 0);
    src_arvalid_i = 4'b0011;
    rst = 0;
    #1;
    chk("post_rst_ready", src_arready_o, 4'b0001);
    arready_i = 1;
    tick;
    chk("post_rst_arid", arid_o, 0);
    chk("post_rst_arvalid", arvalid_o, 1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
